// File: rtl/toss_round_scorer.sv
// ----------------------------------------------------------------------------
// toss_round_scorer
//  Scores one round of ROUND_LEN tosses (one toss per PLAY cycle) by counting
//  hit pulses from the three-heads toss detector. At the end of the round it
//  presents a win/lose verdict on a valid/ack handshake. The verdict is held
//  until the consumer accepts it.
//
// Ports
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous active-low reset
//  start         in   1   request a new round (honoured only in IDLE)
//  hit           in   1   detector pulse, counted only in PLAY
//  result_ack    in   1   verdict accepted (honoured only in DONE)
//  busy          out  1   high while a round is being played
//  toss_cnt      out  CW  tosses in the current / last round
//  hit_cnt       out  CW  hits in the current / last round
//  result_valid  out  1   verdict available
//  win           out  1   verdict, meaningful while result_valid=1
// ----------------------------------------------------------------------------
module toss_round_scorer #(
   parameter int unsigned ROUND_LEN = 16,
   parameter int unsigned WIN_HITS  = 2,
   parameter int unsigned CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hit,
   input  logic          result_ack,
   output logic          busy,
   output logic [CW-1:0] toss_cnt,
   output logic [CW-1:0] hit_cnt,
   output logic          result_valid,
   output logic          win
);

   // One extra bit so the threshold compare cannot overflow.
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [CW-1:0]   r_toss;
   logic [CW-1:0]   r_hit;
   logic            r_busy;
   logic            r_valid;
   logic            r_win;

   logic [CW-1:0]   w_toss_nxt;
   logic [CW-1:0]   w_hit_nxt;
   logic            w_busy_nxt;
   logic            w_valid_nxt;
   logic            w_win_nxt;

   logic            w_last;
   logic [SW-1:0]   w_hit_sum;

   // Current cycle is the final toss of the round.
   assign w_last    = (r_toss == CW'(ROUND_LEN - 1));

   // Hit count including this cycle's pulse; the final toss's hit counts.
   assign w_hit_sum = SW'(r_hit) + SW'(hit);

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_toss_nxt  = r_toss;
      w_hit_nxt   = r_hit;
      w_busy_nxt  = r_busy;
      w_valid_nxt = r_valid;
      w_win_nxt   = r_win;

      case (r_state)
         S_IDLE: begin
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_win_nxt   = 1'b0;
            if (start) begin
               w_state_nxt = S_PLAY;
               w_toss_nxt  = '0;
               w_hit_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end
         end

         S_PLAY: begin
            w_busy_nxt = 1'b1;
            w_toss_nxt = r_toss + CW'(1);
            w_hit_nxt  = w_hit_sum[CW-1:0];
            if (w_last) begin
               w_state_nxt = S_DONE;
               w_busy_nxt  = 1'b0;
               w_valid_nxt = 1'b1;
               w_win_nxt   = (w_hit_sum >= SW'(WIN_HITS));
            end
         end

         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            // Ack wins over a coincident start; start must be re-issued.
            if (result_ack) begin
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
               w_win_nxt   = 1'b0;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_win_nxt   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_toss  <= '0;
         r_hit   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_win   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_toss  <= w_toss_nxt;
         r_hit   <= w_hit_nxt;
         r_busy  <= w_busy_nxt;
         r_valid <= w_valid_nxt;
         r_win   <= w_win_nxt;
      end
   end

   assign busy         = r_busy;
   assign toss_cnt     = r_toss;
   assign hit_cnt      = r_hit;
   assign result_valid = r_valid;
   assign win          = r_win;

endmodule

// File: tb/tb_toss_round_scorer.sv
// ----------------------------------------------------------------------------
// tb_toss_round_scorer
//  Bench for toss_round_scorer: a default-parameter instance plus a
//  ROUND_LEN=1 / WIN_HITS=0 instance. Expected outputs come from a round
//  model: a round is a 16-entry hit pattern, the hit count is the number of
//  set entries so far, and the verdict is count >= 2.
// ----------------------------------------------------------------------------
module tb_toss_round_scorer;

   localparam int unsigned CW   = 8;
   localparam int unsigned RLEN = 16;
   localparam int unsigned WINH = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, hit, ack;
   logic          busy, valid, win;
   logic [CW-1:0] toss_cnt, hit_cnt;

   logic          start1, hit1, ack1;
   logic          busy1, valid1, win1;
   logic [CW-1:0] toss_cnt1, hit_cnt1;

   logic [2*CW+2:0] obs, obs1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   toss_round_scorer #(.ROUND_LEN(RLEN), .WIN_HITS(WINH), .CW(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .hit(hit), .result_ack(ack),
      .busy(busy), .toss_cnt(toss_cnt), .hit_cnt(hit_cnt),
      .result_valid(valid), .win(win)
   );

   toss_round_scorer #(.ROUND_LEN(1), .WIN_HITS(0), .CW(CW)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .hit(hit1), .result_ack(ack1),
      .busy(busy1), .toss_cnt(toss_cnt1), .hit_cnt(hit_cnt1),
      .result_valid(valid1), .win(win1)
   );

   assign obs  = {busy, valid, win, toss_cnt, hit_cnt};
   assign obs1 = {busy1, valid1, win1, toss_cnt1, hit_cnt1};

   // Pack an expected observation {busy, valid, win, toss, hits}.
   function automatic logic [2*CW+2:0] pk(input bit b, input bit v, input bit w,
                                          input int t, input int h);
      return {b, v, w, CW'(t), CW'(h)};
   endfunction

   // Number of hits landing in PLAY cycles 0..c of a pattern.
   function automatic int hits_upto(input logic [RLEN-1:0] pat, input int c);
      int n = 0;
      for (int i = 0; i <= c; i++) n += int'(pat[i]);
      return n;
   endfunction

   // Inputs change on negedge; outputs are read on negedge after each posedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [RLEN-1:0] pat;
      rst = 1'b0; start = 0; hit = 0; ack = 0; start1 = 0; hit1 = 0; ack1 = 0;
      tick(); tick();
      n_cmp++;
      if (obs !== pk(0, 0, 0, 0, 0)) begin
         n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, pk(0, 0, 0, 0, 0));
      end
      rst = 1'b1;
      tick();
      pat = RLEN'($urandom) | RLEN'(1);
      kick();
      for (int c = 0; c < 5; c++) begin
         hit = pat[c];
         tick();
      end
      hit = 1'b0;
      n_cmp++;
      if (obs !== pk(1, 0, 0, 5, hits_upto(pat, 4))) begin
         n_err++; $display("FAIL reset_pre got=%h exp=%h", obs, pk(1, 0, 0, 5, hits_upto(pat, 4)));
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (obs !== pk(0, 0, 0, 0, 0)) begin
         n_err++; $display("FAIL reset_async got=%h exp=%h", obs, pk(0, 0, 0, 0, 0));
      end
      @(negedge clk);
      rst = 1'b1;
      hit = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (obs !== pk(0, 0, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_idle got=%h exp=%h", obs, pk(0, 0, 0, 0, 0));
         end
      end
      hit = 1'b0;
   endtask

   // Plays one full round of pat, checking every PLAY cycle and the verdict.
   task automatic test_round(input logic [RLEN-1:0] pat, input string nm);
      int h;
      kick();
      n_cmp++;
      if (obs !== pk(1, 0, 0, 0, 0)) begin
         n_err++; $display("FAIL %s_start got=%h exp=%h", nm, obs, pk(1, 0, 0, 0, 0));
      end
      for (int c = 0; c < RLEN; c++) begin
         hit = pat[c];
         tick();
         h = hits_upto(pat, c);
         if (c < RLEN - 1) begin
            n_cmp++;
            if (obs !== pk(1, 0, 0, c + 1, h)) begin
               n_err++; $display("FAIL %s_play%0d got=%h exp=%h", nm, c, obs, pk(1, 0, 0, c + 1, h));
            end
         end else begin
            n_cmp++;
            if (obs !== pk(0, 1, h >= WINH, RLEN, h)) begin
               n_err++; $display("FAIL %s_verdict got=%h exp=%h", nm, obs, pk(0, 1, h >= WINH, RLEN, h));
            end
         end
      end
      hit = 1'b0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      h = hits_upto(pat, RLEN - 1);
      n_cmp++;
      if (obs !== pk(0, 0, 0, RLEN, h)) begin
         n_err++; $display("FAIL %s_ack got=%h exp=%h", nm, obs, pk(0, 0, 0, RLEN, h));
      end
   endtask

   task automatic test_win();
      logic [RLEN-1:0] pat = '0;
      pat[3] = 1'b1; pat[9] = 1'b1;
      test_round(pat, "win");
   endtask

   task automatic test_boundary();
      logic [RLEN-1:0] pat = '0;
      pat[0] = 1'b1;
      test_round(pat, "first_only");
      pat = '0; pat[5] = 1'b1; pat[RLEN-1] = 1'b1;
      test_round(pat, "last_hit");
      test_round('0, "no_hits");
      test_round('1, "all_hits");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) test_round(RLEN'($urandom), "rand");
   endtask

   task automatic test_ignored();
      logic [RLEN-1:0] pat = RLEN'($urandom);
      int h = hits_upto(pat, RLEN - 1);
      kick();
      for (int c = 0; c < RLEN; c++) begin
         hit   = pat[c];
         start = (c % 3 == 1);
         tick();
      end
      start = 1'b0;
      n_cmp++;
      if (obs !== pk(0, 1, h >= WINH, RLEN, h)) begin
         n_err++; $display("FAIL ign_play got=%h exp=%h", obs, pk(0, 1, h >= WINH, RLEN, h));
      end
      hit = 1'b1;
      for (int c = 0; c < 4; c++) begin
         start = c[0];
         tick();
         n_cmp++;
         if (obs !== pk(0, 1, h >= WINH, RLEN, h)) begin
            n_err++; $display("FAIL ign_done got=%h exp=%h", obs, pk(0, 1, h >= WINH, RLEN, h));
         end
      end
      start = 1'b0;
      ack   = 1'b1;
      tick();
      ack   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if (obs !== pk(0, 0, 0, RLEN, h)) begin
            n_err++; $display("FAIL ign_idle got=%h exp=%h", obs, pk(0, 0, 0, RLEN, h));
         end
      end
      hit = 1'b0;
   endtask

   task automatic test_handshake();
      logic [RLEN-1:0] pat = RLEN'($urandom) | RLEN'(3);
      int h = hits_upto(pat, RLEN - 1);
      kick();
      for (int c = 0; c < RLEN; c++) begin
         hit = pat[c];
         tick();
      end
      for (int c = 0; c < 7; c++) begin
         hit = 1'(c);
         tick();
         n_cmp++;
         if (obs !== pk(0, 1, 1, RLEN, h)) begin
            n_err++; $display("FAIL hs_hold%0d got=%h exp=%h", c, obs, pk(0, 1, 1, RLEN, h));
         end
      end
      hit = 1'b0;
      ack = 1'b1; start = 1'b1;
      tick();
      ack = 1'b0; start = 1'b0;
      n_cmp++;
      if (obs !== pk(0, 0, 0, RLEN, h)) begin
         n_err++; $display("FAIL hs_ack_start got=%h exp=%h", obs, pk(0, 0, 0, RLEN, h));
      end
      tick();
      n_cmp++;
      if (obs !== pk(0, 0, 0, RLEN, h)) begin
         n_err++; $display("FAIL hs_no_round got=%h exp=%h", obs, pk(0, 0, 0, RLEN, h));
      end
      test_round(RLEN'($urandom), "hs_next");
   endtask

   task automatic test_params();
      for (int r = 0; r < 2; r++) begin
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         n_cmp++;
         if (obs1 !== pk(1, 0, 0, 0, 0)) begin
            n_err++; $display("FAIL p1_start got=%h exp=%h", obs1, pk(1, 0, 0, 0, 0));
         end
         hit1 = 1'(r);
         tick();
         hit1 = 1'b0;
         n_cmp++;
         if (obs1 !== pk(0, 1, 1, 1, r)) begin
            n_err++; $display("FAIL p1_verdict got=%h exp=%h", obs1, pk(0, 1, 1, 1, r));
         end
         ack1 = 1'b1;
         tick();
         ack1 = 1'b0;
         n_cmp++;
         if (obs1 !== pk(0, 0, 0, 1, r)) begin
            n_err++; $display("FAIL p1_ack got=%h exp=%h", obs1, pk(0, 0, 0, 1, r));
         end
      end
   endtask

   initial begin
      test_reset();
      test_win();
      test_boundary();
      test_random();
      test_ignored();
      test_handshake();
      test_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
